// File: rtl/mcycle_muldiv.sv
// Purpose: iterative radix-2 multiply (shift-add) / divide (restoring) unit beside the ALU.
// Latency: Start at edge k -> Busy cycles k+1..k+WIDTH+1, Done pulse and results in cycle k+WIDTH+2.
// Backpressure: none; Busy stalls the pipeline, Start is ignored unless the unit is idle.
// Ports: CLK/RESET (sync, active high); Start + MCycleOp {signed, divide} + Operand1 (Rn) /
//        Operand2 (shifter output) request an operation; Result1 = product low / quotient,
//        Result2 = product high / remainder; Busy while in flight; Done one-cycle valid pulse.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t state, stateNext;

    logic [CW-1:0]    cnt;
    logic             isDiv;
    logic             signDiff;   // operand signs differ (signed mode only)
    logic             dividendNeg;
    logic [WIDTH-1:0] op1Raw;     // kept for the divide-by-zero remainder
    logic [WIDTH-1:0] magA;       // |Operand1|: multiplicand / dividend
    logic [WIDTH-1:0] magB;       // |Operand2|: multiplier / divisor
    logic [WIDTH-1:0] accHi;      // partial product high / running remainder
    logic [WIDTH-1:0] accLo;      // multiplier bits shifting out / quotient bits shifting in

    // Operand magnitudes at the Start edge. The most-negative value negates to itself,
    // which read as unsigned is already the correct magnitude.
    logic             op1Neg, op2Neg;
    logic [WIDTH-1:0] op1Mag, op2Mag;

    always_comb begin
        op1Neg = MCycleOp[1] & Operand1[WIDTH-1];
        op2Neg = MCycleOp[1] & Operand2[WIDTH-1];
        op1Mag = op1Neg ? -Operand1 : Operand1;
        op2Mag = op2Neg ? -Operand2 : Operand2;
    end

    // One iteration of each algorithm.
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divGeq;
    logic [2*WIDTH-1:0] prodRaw, prodFinal;
    logic [WIDTH-1:0]   quotFinal, remFinal;

    always_comb begin
        mulSum    = {1'b0, accHi} + {1'b0, (accLo[0] ? magA : {WIDTH{1'b0}})};
        divShift  = {accHi, accLo[WIDTH-1]};
        divGeq    = divShift >= {1'b0, magB};
        divDiff   = divShift - {1'b0, magB};
        prodRaw   = {accHi, accLo};
        prodFinal = signDiff ? -prodRaw : prodRaw;
        quotFinal = signDiff ? -accLo : accLo;
        remFinal  = dividendNeg ? -accHi : accHi;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Start) stateNext = COMPUTE;
            COMPUTE: if (cnt == LAST) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt         <= '0;
            isDiv       <= 1'b0;
            signDiff    <= 1'b0;
            dividendNeg <= 1'b0;
            op1Raw      <= '0;
            magA        <= '0;
            magB        <= '0;
            accHi       <= '0;
            accLo       <= '0;
            Result1     <= '0;
            Result2     <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        cnt         <= '0;
                        isDiv       <= MCycleOp[0];
                        signDiff    <= op1Neg ^ op2Neg;
                        dividendNeg <= op1Neg;
                        op1Raw      <= Operand1;
                        magA        <= op1Mag;
                        magB        <= op2Mag;
                        accHi       <= '0;
                        // Multiply shifts the multiplier out of accLo; divide shifts the dividend out.
                        accLo       <= MCycleOp[0] ? op1Mag : op2Mag;
                        Busy        <= 1'b1;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 1'b1;
                    if (isDiv) begin
                        // Remainder stays below magB, so the difference always fits WIDTH bits.
                        accHi <= divGeq ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], divGeq};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    if (!isDiv) begin
                        {Result2, Result1} <= prodFinal;
                    end else if (magB == '0) begin
                        Result1 <= '1;
                        Result2 <= op1Raw;
                    end else begin
                        Result1 <= quotFinal;
                        Result2 <= remFinal;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcycle_muldiv.sv
module tb_mcycle_muldiv;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  MCycleOp = 2'b00;
    logic [31:0] Operand1 = '0;
    logic [31:0] Operand2 = '0;
    logic [31:0] Result1, Result2;
    logic        Busy, Done;

    int checks = 0;
    int failures = 0;

    mcycle_muldiv #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present an operation and clock it in; returns in the first Busy cycle.
    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
    endtask

    // Count Busy cycles from the current cycle until Done is seen (bounded).
    task automatic waitDone(output int busyCycles, output bit timedOut);
        busyCycles = 0;
        timedOut   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (Done) begin
                timedOut = 1'b0;
                break;
            end
            if (Busy) busyCycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (Result1 !== 32'h0) begin failures++; $display("FAIL reset_r1: got %h want 0", Result1); end
        checks++; if (Result2 !== 32'h0) begin failures++; $display("FAIL reset_r2: got %h want 0", Result2); end
    endtask

    task automatic test_unsigned_mul();
        int  bc;
        bit  to;
        startOp(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL umul_busy_rise: got %b want 1", Busy); end
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL umul_timeout: no Done within bound"); end
        checks++; if (bc != 33) begin failures++; $display("FAIL umul_busy_len: got %0d want 33", bc); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL umul_busy_at_done: got %b want 0", Busy); end
        checks++; if (Result1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL umul_r1: got %h want fffffffe", Result1); end
        checks++; if (Result2 !== 32'h0000_0001) begin failures++; $display("FAIL umul_r2: got %h want 00000001", Result2); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL umul_done_pulse: got %b want 0", Done); end
        checks++; if (Result1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL umul_r1_hold: got %h want fffffffe", Result1); end
    endtask

    task automatic test_signed_mul();
        int  bc;
        bit  to;
        startOp(2'b10, 32'hFFFF_FFFD, 32'h0000_0007);
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL smul_timeout: no Done within bound"); end
        checks++; if (Result1 !== 32'hFFFF_FFEB) begin failures++; $display("FAIL smul_r1: got %h want ffffffeb", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL smul_r2: got %h want ffffffff", Result2); end
        tick();
    endtask

    task automatic test_back_to_back();
        int  bc;
        bit  to;
        startOp(2'b01, 32'd100, 32'd7);
        // Hold Start with the second operation's operands; ignored until IDLE.
        MCycleOp = 2'b11;
        Operand1 = 32'hFFFF_FF9C;
        Operand2 = 32'd7;
        Start    = 1'b1;
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_udiv_timeout: no Done within bound"); end
        checks++; if (bc != 33) begin failures++; $display("FAIL b2b_udiv_busy_len: got %0d want 33", bc); end
        checks++; if (Result1 !== 32'd14) begin failures++; $display("FAIL b2b_udiv_q: got %h want 0000000e", Result1); end
        checks++; if (Result2 !== 32'd2) begin failures++; $display("FAIL b2b_udiv_r: got %h want 00000002", Result2); end
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_after_done: got %b want 1", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL b2b_done_low: got %b want 0", Done); end
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_sdiv_timeout: no Done within bound"); end
        checks++; if (bc != 33) begin failures++; $display("FAIL b2b_sdiv_busy_len: got %0d want 33", bc); end
        checks++; if (Result1 !== 32'hFFFF_FFF2) begin failures++; $display("FAIL b2b_sdiv_q: got %h want fffffff2", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_sdiv_r: got %h want fffffffe", Result2); end
        tick();
    endtask

    task automatic test_div_corner();
        int  bc;
        bit  to;
        startOp(2'b01, 32'h1234_5678, 32'h0);
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL div0_timeout: no Done within bound"); end
        checks++; if (Result1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_q: got %h want ffffffff", Result1); end
        checks++; if (Result2 !== 32'h1234_5678) begin failures++; $display("FAIL div0_r: got %h want 12345678", Result2); end
        tick();
        startOp(2'b11, 32'hFFFF_FFFB, 32'h0);
        waitDone(bc, to);
        checks++; if (Result1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sdiv0_q: got %h want ffffffff", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFFB) begin failures++; $display("FAIL sdiv0_r: got %h want fffffffb", Result2); end
        tick();
        startOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL ovf_timeout: no Done within bound"); end
        checks++; if (Result1 !== 32'h8000_0000) begin failures++; $display("FAIL ovf_q: got %h want 80000000", Result1); end
        checks++; if (Result2 !== 32'h0) begin failures++; $display("FAIL ovf_r: got %h want 00000000", Result2); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int  bc;
        bit  to;
        int  extraDone;
        int  extraBusy;
        startOp(2'b00, 32'd6, 32'd7);
        MCycleOp = 2'b01;
        Operand1 = 32'd99;
        Operand2 = 32'd123;
        Start    = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        Start = 1'b0;
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL swb_timeout: no Done within bound"); end
        checks++; if (bc != 13) begin failures++; $display("FAIL swb_busy_left: got %0d want 13", bc); end
        checks++; if (Result1 !== 32'd42) begin failures++; $display("FAIL swb_r1: got %h want 0000002a", Result1); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL swb_r2: got %h want 00000000", Result2); end
        extraDone = 0;
        extraBusy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) extraDone++;
            if (Busy) extraBusy++;
        end
        checks++; if (extraDone != 0) begin failures++; $display("FAIL swb_extra_done: got %0d want 0", extraDone); end
        checks++; if (extraBusy != 0) begin failures++; $display("FAIL swb_extra_busy: got %0d want 0", extraBusy); end
    endtask

    task automatic test_reset_mid();
        int  bc;
        bit  to;
        int  seenDone;
        int  seenBusy;
        startOp(2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b want 0", Done); end
        checks++; if (Result1 !== 32'h0) begin failures++; $display("FAIL rst_mid_r1: got %h want 0", Result1); end
        checks++; if (Result2 !== 32'h0) begin failures++; $display("FAIL rst_mid_r2: got %h want 0", Result2); end
        seenDone = 0;
        seenBusy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) seenDone++;
            if (Busy) seenBusy++;
        end
        checks++; if (seenDone != 0) begin failures++; $display("FAIL rst_mid_late_done: got %0d want 0", seenDone); end
        checks++; if (seenBusy != 0) begin failures++; $display("FAIL rst_mid_late_busy: got %0d want 0", seenBusy); end
        startOp(2'b10, 32'd9, 32'd9);
        waitDone(bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL rst_after_timeout: no Done within bound"); end
        checks++; if (bc != 33) begin failures++; $display("FAIL rst_after_busy_len: got %0d want 33", bc); end
        checks++; if (Result1 !== 32'd81) begin failures++; $display("FAIL rst_after_r1: got %h want 00000051", Result1); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL rst_after_r2: got %h want 00000000", Result2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned_mul();
        test_signed_mul();
        test_back_to_back();
        test_div_corner();
        test_start_while_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mcycle_muldiv.md
Name: mcycle_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit in the processor's execute stage, in parallel with the ALU.
- Operand2 is the post-shifter Src2 value, i.e. the output of the barrel-shifter stage.
- Operand1 is the Rn register value.
- Asserts Busy while computing so the control unit stalls the pipeline.
- Returns a two-word result: product low/high, or quotient/remainder.

Parameters:
- WIDTH, 32, operand and result word width. Must be even and at least 4.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- MCycleOp  input  2  bit0: 0=multiply, 1=divide. bit1: 0=unsigned, 1=signed (two's complement).
- Operand1  input  WIDTH  multiplicand / dividend (Rn).
- Operand2  input  WIDTH  multiplier / divisor (shifter output).
- Result1  output  WIDTH  product[WIDTH-1:0] or quotient.
- Result2  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when results become valid.

Behaviour:
- Reset: this is the only reset; all state is cleared synchronously at the clock edge while RESET=1.
  - State goes to IDLE.
  - Busy=0, Done=0, Result1=0, Result2=0, internal counter cleared.
  - RESET overrides Start and aborts any operation in flight; no Done pulse is produced.
- All outputs are registered.
- FSM states: IDLE, COMPUTE, FINISH.
- IDLE:
  - Start=1 at edge k: latch Operand1, Operand2 and MCycleOp; counter=0; go to COMPUTE; Busy=1 from cycle k+1.
  - Start=0: stay in IDLE.
  - Result1/Result2 hold their last values.
- COMPUTE:
  - One radix-2 iteration per cycle, exactly WIDTH cycles (counter 0..WIDTH-1); then go to FINISH.
  - Start is ignored. Operand inputs may change freely; only the latched copies are used.
- FINISH (one cycle):
  - Apply sign correction and write Result1/Result2.
  - Busy=0 and Done=1 at the following edge; go to IDLE.
- Total latency:
  - Start sampled at edge k; Busy high for cycles k+1 .. k+WIDTH+1 (WIDTH+1 cycles).
  - Results valid and Done=1 in cycle k+WIDTH+2.
  - Results hold until the next operation's FINISH; they are not cleared by a new Start.
- Start=1 in the cycle Done=1 (state IDLE) is accepted normally: back-to-back operations are allowed.
- Multiply:
  - Shift-add over the magnitudes, 2*WIDTH-bit product.
  - Signed mode: operate on magnitudes, then negate the 2*WIDTH product if the operand signs differ.
  - Unsigned mode: plain product.
- Divide:
  - Restoring shift-subtract over magnitudes.
  - Signed mode: quotient truncates toward zero; quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Divisor=0 (either mode): Result1 = all ones; Result2 = Operand1 as latched; no exception signal.
  - Signed most-negative / -1: Result1 = 100..0 (wraps), Result2 = 0.
- Magnitude of the most-negative value is taken as an unsigned WIDTH-bit number (no extra bit is needed).
- Busy is never high while Done is high.

Test Plan:
- Unsigned multiply:
  - Stimulus: Operand1=0xFFFFFFFF, Operand2=0x00000002, MCycleOp=00, Start pulse.
  - Response: Busy high exactly 33 cycles; Done one cycle; Result1=0xFFFFFFFE, Result2=0x00000001.
- Signed multiply:
  - Stimulus: Operand1=0xFFFFFFFD (-3), Operand2=0x00000007, MCycleOp=10.
  - Response: Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
- Divide, two operations back-to-back with Start held across Done:
  - Unsigned: 100/7 (MCycleOp=01) gives Result1=14, Result2=2.
  - Signed: -100/7 (MCycleOp=11) gives Result1=0xFFFFFFF2, Result2=0xFFFFFFFE.
  - Required: the second operation's Busy rises in the cycle after Done.
- Divide corner cases:
  - Stimulus 1: 0x12345678/0, MCycleOp=01.
  - Response 1: Result1=0xFFFFFFFF, Result2=0x12345678.
  - Stimulus 2: 0x80000000 / 0xFFFFFFFF, MCycleOp=11.
  - Response 2: Result1=0x80000000, Result2=0.
- Start while busy and operand changes mid-operation:
  - Stimulus: start 6*7; drive Start=1 and different operands during COMPUTE.
  - Response: result stays 42/0; no second operation begins until IDLE; only one Done pulse.
- Reset mid-operation:
  - Stimulus: assert RESET at COMPUTE cycle 10.
  - Response: next edge gives Busy=0, Done=0, Result1=Result2=0, state IDLE; no Done pulse afterwards; a subsequent Start completes with correct full latency.
